// File: rtl/multdiv_controller.sv
// multdiv_controller
// Sequencer between the execute stage and the shared multiply/divide unit.
// Accepts one request at a time, latches operands, holds the selected
// start line (unit_ctrl_MULT / unit_ctrl_DIV) high until the unit reports
// result-ready or the wait times out, then holds the response with its
// destination tag until writeback takes it. Flush kills any in-flight op.
//
// Ports
//   clock, reset          rising-edge clock, synchronous active-high reset
//   flush                 synchronous kill of the in-flight operation
//   req_*                 request from execute (valid/ready handshake)
//   unit_operandA/B       latched operands to the unit
//   unit_ctrl_MULT/DIV    level-held start lines
//   unit_result/exception/resultRDY  unit response, sampled only in WAIT
//   rsp_*                 response to writeback (valid/ready handshake)
//
// Optional feature macro: MULTDIV_ZERO_BYPASS_EN
//   When defined, multiplies with a zero operand and divides by zero are
//   answered directly without starting the unit.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready for a request, both start lines low
// ISSUE | start line raised, timeout counter cleared (one cycle)
// WAIT  | start line held, waiting for unit_resultRDY or timeout
// DONE  | response valid and held until rsp_ready

module multdiv_controller #(
   parameter int TIMEOUT_CYCLES = 40,
   parameter int CNT_W          = 6
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        flush,
   input  logic        req_valid,
   input  logic        req_op,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   input  logic [4:0]  req_tag,
   output logic        req_ready,
   output logic [31:0] unit_operandA,
   output logic [31:0] unit_operandB,
   output logic        unit_ctrl_MULT,
   output logic        unit_ctrl_DIV,
   input  logic [31:0] unit_result,
   input  logic        unit_exception,
   input  logic        unit_resultRDY,
   output logic        rsp_valid,
   output logic [31:0] rsp_result,
   output logic        rsp_exception,
   output logic [4:0]  rsp_tag,
   input  logic        rsp_ready
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [4:0]       tag_q;
   logic             range_err;
   logic             zero_mult;
   logic             zero_div;

   // The multiplier only consumes B[15:0]; anything not sign-representable
   // in 16 bits would silently produce a wrong product, so reject it.
   assign range_err = ~req_op & (req_b[31:16] != {16{req_b[15]}});

`ifdef MULTDIV_ZERO_BYPASS_EN
   assign zero_mult = ~req_op & ((req_a == '0) | (req_b == '0));
   assign zero_div  = req_op & (req_b == '0);
`else
   assign zero_mult = 1'b0;
   assign zero_div  = 1'b0;
`endif

   assign req_ready = (state == IDLE);

   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= IDLE;
         cnt            <= '0;
         tag_q          <= '0;
         unit_operandA  <= '0;
         unit_operandB  <= '0;
         unit_ctrl_MULT <= 1'b0;
         unit_ctrl_DIV  <= 1'b0;
         rsp_valid      <= 1'b0;
         rsp_result     <= '0;
         rsp_exception  <= 1'b0;
         rsp_tag        <= '0;
      end else if (flush) begin
         // rsp_result/exception/tag intentionally keep their last values
         state          <= IDLE;
         unit_ctrl_MULT <= 1'b0;
         unit_ctrl_DIV  <= 1'b0;
         rsp_valid      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  unit_operandA <= req_a;
                  unit_operandB <= req_b;
                  tag_q         <= req_tag;
                  if (range_err | zero_mult | zero_div) begin
                     // answered locally; range error wins over the bypass
                     state         <= DONE;
                     rsp_valid     <= 1'b1;
                     rsp_result    <= '0;
                     rsp_exception <= range_err | zero_div;
                     rsp_tag       <= req_tag;
                  end else begin
                     // start line is registered here so it is already high
                     // throughout the ISSUE cycle
                     state          <= ISSUE;
                     unit_ctrl_MULT <= ~req_op;
                     unit_ctrl_DIV  <= req_op;
                  end
               end
            end
            ISSUE: begin
               cnt   <= '0;
               state <= WAIT;
            end
            WAIT: begin
               if (unit_resultRDY) begin
                  state          <= DONE;
                  unit_ctrl_MULT <= 1'b0;
                  unit_ctrl_DIV  <= 1'b0;
                  rsp_valid      <= 1'b1;
                  rsp_result     <= unit_result;
                  rsp_exception  <= unit_exception;
                  rsp_tag        <= tag_q;
               end else if (cnt == CNT_LAST) begin
                  state          <= DONE;
                  unit_ctrl_MULT <= 1'b0;
                  unit_ctrl_DIV  <= 1'b0;
                  rsp_valid      <= 1'b1;
                  rsp_result     <= '0;
                  rsp_exception  <= 1'b1;
                  rsp_tag        <= tag_q;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               if (rsp_ready) begin
                  state     <= IDLE;
                  rsp_valid <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_multdiv_controller.sv
`timescale 1ns/1ps
module tb_multdiv_controller;

   localparam int TO = 40;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        flush = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_op = 1'b0;
   logic [31:0] req_a = '0;
   logic [31:0] req_b = '0;
   logic [4:0]  req_tag = '0;
   logic        req_ready;
   logic [31:0] unit_operandA, unit_operandB;
   logic        unit_ctrl_MULT, unit_ctrl_DIV;
   logic [31:0] unit_result;
   logic        unit_exception;
   logic        unit_resultRDY;
   logic        rsp_valid;
   logic [31:0] rsp_result;
   logic        rsp_exception;
   logic [4:0]  rsp_tag;
   logic        rsp_ready = 1'b0;

   // unit stand-in: answers on WAIT cycle number unit_lat (-1 = never)
   int          unit_lat = -1;
   logic [31:0] unit_res = '0;
   logic        unit_exc = 1'b0;
   logic        rdy_r = 1'b0;
   logic        stray = 1'b0;
   int          hi_cnt = 0;

   assign unit_result    = unit_res;
   assign unit_exception = unit_exc;
   assign unit_resultRDY = rdy_r | stray;

   int n_cmp = 0;
   int n_err = 0;

   multdiv_controller #(.TIMEOUT_CYCLES(TO), .CNT_W(6)) dut (
      .clock(clock), .reset(reset), .flush(flush),
      .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
      .req_tag(req_tag), .req_ready(req_ready),
      .unit_operandA(unit_operandA), .unit_operandB(unit_operandB),
      .unit_ctrl_MULT(unit_ctrl_MULT), .unit_ctrl_DIV(unit_ctrl_DIV),
      .unit_result(unit_result), .unit_exception(unit_exception),
      .unit_resultRDY(unit_resultRDY),
      .rsp_valid(rsp_valid), .rsp_result(rsp_result),
      .rsp_exception(rsp_exception), .rsp_tag(rsp_tag), .rsp_ready(rsp_ready)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      #1;
      if (unit_ctrl_MULT | unit_ctrl_DIV) hi_cnt = hi_cnt + 1;
      else hi_cnt = 0;
      // cycle 1 of a start pulse is ISSUE, so WAIT cycle k is pulse cycle k+1
      rdy_r = (unit_lat >= 0) && (hi_cnt == unit_lat + 1);
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic bound_fail(input string nm);
      n_cmp++;
      n_err++;
      $display("FAIL %s: wait bound expired at %0t", nm, $time);
   endtask

   // ---------------- behavioural model ----------------
   // m_busy: accepted op still with the unit; m_age: cycles since acceptance
   // (1 = issue cycle, 2.. = waiting). m_resp: a response is owed.
   logic        m_on = 1'b0;
   logic        m_busy = 1'b0;
   logic        m_resp = 1'b0;
   logic        m_op = 1'b0;
   int          m_age = 0;
   logic [31:0] m_a = '0, m_b = '0, m_res = '0;
   logic        m_exc = 1'b0;
   logic [4:0]  m_tag = '0;

   task automatic finish_op(input logic [31:0] r, input logic e);
      m_busy = 1'b0;
      m_resp = 1'b1;
      m_res  = r;
      m_exc  = e;
   endtask

   always @(posedge clock) begin
      if (reset) begin
         m_on = 1'b1; m_busy = 1'b0; m_resp = 1'b0; m_age = 0;
         m_a = '0; m_b = '0; m_res = '0; m_exc = 1'b0; m_tag = '0;
      end else if (flush) begin
         m_busy = 1'b0;
         m_resp = 1'b0;
      end else if (m_resp) begin
         if (rsp_ready) m_resp = 1'b0;
      end else if (m_busy) begin
         if (m_age >= 2 && unit_resultRDY) finish_op(unit_result, unit_exception);
         else if (m_age - 2 == TO - 1) finish_op(32'd0, 1'b1);
         else m_age = m_age + 1;
      end else if (req_valid) begin
         m_a = req_a; m_b = req_b; m_op = req_op; m_tag = req_tag;
         if (!req_op && ($signed(req_b) > 32767 || $signed(req_b) < -32768))
            finish_op(32'd0, 1'b1);
`ifdef MULTDIV_ZERO_BYPASS_EN
         else if (!req_op && (req_a == 0 || req_b == 0)) finish_op(32'd0, 1'b0);
         else if (req_op && req_b == 0) finish_op(32'd0, 1'b1);
`endif
         else begin
            m_busy = 1'b1;
            m_age  = 1;
         end
      end
   end

   // ---------------- compare + monitor ----------------
   int          mult_hi = 0, div_hi = 0, rspv_cnt = 0;
   logic [31:0] cap_res = '0;
   logic        cap_exc = 1'b0;
   logic [4:0]  cap_tag = '0;

   always @(negedge clock) begin
      if (m_on) begin
         check("req_ready", req_ready, !m_busy && !m_resp);
         check("ctrl_mult", unit_ctrl_MULT, m_busy && !m_op);
         check("ctrl_div", unit_ctrl_DIV, m_busy && m_op);
         check("ctrl_excl", unit_ctrl_MULT & unit_ctrl_DIV, 1'b0);
         check("rsp_valid", rsp_valid, m_resp);
         check("operand_a", unit_operandA, m_a);
         check("operand_b", unit_operandB, m_b);
         if (m_resp) begin
            check("rsp_result", rsp_result, m_res);
            check("rsp_exception", rsp_exception, m_exc);
            check("rsp_tag", rsp_tag, m_tag);
         end
      end
      if (unit_ctrl_MULT) mult_hi++;
      if (unit_ctrl_DIV) div_hi++;
      if (rsp_valid) begin
         rspv_cnt++;
         cap_res = rsp_result;
         cap_exc = rsp_exception;
         cap_tag = rsp_tag;
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clr();
      mult_hi = 0; div_hi = 0; rspv_cnt = 0;
   endtask

   task automatic send(input logic op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag);
      int n = 0;
      req_op = op; req_a = a; req_b = b; req_tag = tag; req_valid = 1'b1;
      while (!req_ready && n < 100) begin
         tick();
         n++;
      end
      if (!req_ready) bound_fail("send_accept");
      tick();
      req_valid = 1'b0;
   endtask

   task automatic wait_rsp(input int limit);
      int n = 0;
      while (!rsp_valid && n < limit) begin
         tick();
         n++;
      end
      if (!rsp_valid) bound_fail("wait_rsp");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset for two edges
      tick(); tick();
      reset = 1'b0;
      tick();
      check("rst_req_ready", req_ready, 1'b1);
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_ctrl", {unit_ctrl_MULT, unit_ctrl_DIV}, 2'b00);
      check("rst_operand_a", unit_operandA, 32'd0);

      // multiply 7*6, unit answers on WAIT cycle 5
      rsp_ready = 1'b1; unit_lat = 5; unit_res = 32'd42; unit_exc = 1'b0;
      clr();
      send(1'b0, 32'd7, 32'd6, 5'd3);
      wait_rsp(20);
      tick(); tick(); tick();
      check("mult_ctrl_cycles", mult_hi, 6);
      check("mult_rsp_cycles", rspv_cnt, 1);
      check("mult_result", cap_res, 32'd42);
      check("mult_exc", cap_exc, 1'b0);
      check("mult_tag", cap_tag, 5'd3);

      // multiplier operand out of 16-bit range
      unit_lat = -1;
      clr();
      send(1'b0, 32'd5, 32'h0001_0000, 5'd4);
      check("range_latency", rsp_valid, 1'b1);
      tick(); tick(); tick();
      check("range_ctrl_cycles", mult_hi, 0);
      check("range_rsp_cycles", rspv_cnt, 1);
      check("range_exc", cap_exc, 1'b1);
      check("range_result", cap_res, 32'd0);
      check("range_tag", cap_tag, 5'd4);

      // divide that never completes -> timeout
      clr();
      send(1'b1, 32'd100, 32'd7, 5'd5);
      wait_rsp(60);
      tick(); tick();
      check("to_ctrl_cycles", div_hi, TO + 1);
      check("to_exc", cap_exc, 1'b1);
      check("to_result", cap_res, 32'd0);

      // flush in third WAIT cycle, then a stray ready pulse
      clr();
      send(1'b1, 32'd50, 32'd5, 5'd6);
      tick(); tick(); tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_ctrl_drop", unit_ctrl_DIV, 1'b0);
      check("flush_idle", req_ready, 1'b1);
      stray = 1'b1;
      tick();
      stray = 1'b0;
      tick(); tick(); tick();
      check("flush_no_rsp", rspv_cnt, 0);
      check("flush_ctrl_cycles", div_hi, 4);

      // response stalled 4 cycles with a new request waiting
      clr();
      rsp_ready = 1'b0; unit_lat = 1; unit_res = 32'd25;
      send(1'b0, 32'd5, 32'd5, 5'd7);
      wait_rsp(20);
      req_op = 1'b0; req_a = 32'hFFFF_FFFD; req_b = 32'hFFFF_FFFE; req_tag = 5'd8;
      req_valid = 1'b1; unit_lat = 2; unit_res = 32'd6;
      tick(); tick(); tick(); tick();
      check("stall_result_hold", rsp_result, 32'd25);
      check("stall_req_ready", req_ready, 1'b0);
      rsp_ready = 1'b1;
      tick();
      check("post_hs_ready", req_ready, 1'b1);
      check("stall_rsp_cycles", rspv_cnt, 5);
      tick();
      req_valid = 1'b0;
      check("next_issue", unit_ctrl_MULT, 1'b1);
      wait_rsp(20);
      tick();
      check("neg_mult_result", cap_res, 32'd6);
      check("neg_mult_tag", cap_tag, 5'd8);

      // zero operands: bypassed or issued, same response either way
      clr();
      unit_lat = 2; unit_res = 32'd0; unit_exc = 1'b0;
      send(1'b0, 32'd0, 32'd9, 5'd9);
      wait_rsp(20);
      tick();
      check("zero_mult_result", cap_res, 32'd0);
      check("zero_mult_exc", cap_exc, 1'b0);
`ifdef MULTDIV_ZERO_BYPASS_EN
      check("zero_mult_ctrl", mult_hi, 0);
`else
      check("zero_mult_ctrl", mult_hi, 3);
`endif
      unit_exc = 1'b1;
      send(1'b1, 32'd9, 32'd0, 5'd10);
      wait_rsp(20);
      tick();
      unit_exc = 1'b0;
      check("div0_exc", cap_exc, 1'b1);
      check("div0_tag", cap_tag, 5'd10);

      // flush while idle with a request present
      clr();
      req_op = 1'b0; req_a = 32'd2; req_b = 32'd3; req_tag = 5'd1;
      req_valid = 1'b1; flush = 1'b1;
      tick();
      flush = 1'b0; req_valid = 1'b0;
      check("flush_idle_ready", req_ready, 1'b1);
      tick();
      check("flush_idle_noissue", mult_hi, 0);

      // flush while holding a response
      rsp_ready = 1'b0; unit_lat = 1; unit_res = 32'd99;
      send(1'b0, 32'd9, 32'd11, 5'd11);
      wait_rsp(20);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_done_valid", rsp_valid, 1'b0);
      rsp_ready = 1'b1;

      // reset in the middle of a divide
      unit_lat = -1;
      send(1'b1, 32'd77, 32'd3, 5'd12);
      tick(); tick(); tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("midrst_ctrl", unit_ctrl_DIV, 1'b0);
      check("midrst_operand_a", unit_operandA, 32'd0);
      check("midrst_tag", rsp_tag, 5'd0);
      check("midrst_ready", req_ready, 1'b1);
      tick(); tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/multdiv_controller.md
Name: multdiv_controller

Overview:
Sequencer sitting between the pipeline execute stage and the shared multiply/divide unit. It accepts one mult or div request at a time, latches the operands, and drives the level-held ctrl_MULT/ctrl_DIV start lines. It waits for the unit's result-ready, captures result and exception, and holds the response with its destination tag until writeback accepts it. It also provides the stall (req_ready), flush, and timeout handling the bare unit lacks.

Parameters:
TIMEOUT_CYCLES, 40, WAIT-state cycles allowed before forcing an exception response
CNT_W, 6, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
clock  input  1  single system clock, rising edge
reset  input  1  synchronous, active-high reset
flush  input  1  synchronous kill of any in-flight operation
req_valid  input  1  execute stage presents a request
req_op  input  1  0 = multiply, 1 = divide
req_a  input  32  operand A
req_b  input  32  operand B
req_tag  input  5  destination register number
req_ready  output  1  controller can accept a request; stall = ~req_ready
unit_operandA  output  32  latched operand A to the unit
unit_operandB  output  32  latched operand B; the multiplier consumes [15:0]
unit_ctrl_MULT  output  1  held high for the entire multiply
unit_ctrl_DIV  output  1  held high for the entire divide
unit_result  input  32  unit result
unit_exception  input  1  unit exception flag
unit_resultRDY  input  1  unit result valid
rsp_valid  output  1  response pending
rsp_result  output  32  captured result
rsp_exception  output  1  captured or generated exception
rsp_tag  output  5  latched req_tag
rsp_ready  input  1  writeback accepts response

Behaviour:
- States: IDLE, ISSUE, WAIT, DONE. All registered outputs update on the clock edge.
- Reset state: IDLE. req_ready=1. unit_ctrl_MULT=0, unit_ctrl_DIV=0, rsp_valid=0, rsp_result=0, rsp_exception=0, rsp_tag=0, operand registers=0, counter=0.
- req_ready=1 only in IDLE. req_ready is combinational from state.
- IDLE, req_valid=1, flush=0: latch req_a, req_b, req_op, req_tag.
  - Range check: if req_op=0 and req_b[31:16] is not all equal to req_b[15], go directly to DONE with rsp_result=0 and rsp_exception=1; the unit is not started.
  - Otherwise go to ISSUE.
- ISSUE: one cycle. The ctrl line selected by op goes high. Counter cleared. Next state WAIT.
- WAIT: the ctrl line stays high. Counter increments each cycle. unit_resultRDY is sampled only in WAIT.
  - On unit_resultRDY=1: capture unit_result and unit_exception into rsp_*, drop the ctrl line, go to DONE.
  - If the counter reaches TIMEOUT_CYCLES-1 with no ready: rsp_result=0, rsp_exception=1, drop ctrl, go to DONE.
- Minimum latency: accepted at edge 0; ISSUE in cycle 1; ready seen in cycle 2; rsp_valid=1 in cycle 3.
- DONE: rsp_valid=1 with rsp_* held stable. When rsp_ready=1, go to IDLE; rsp_valid=0 from the next cycle. A new request is accepted no earlier than the cycle after the handshake.
- Both ctrl lines are 0 in IDLE and DONE. They are never high simultaneously.
- Priority: reset > flush > normal operation.
  - flush in ISSUE, WAIT, or DONE: go to IDLE, drop ctrl, rsp_valid=0, discard the result. rsp_result, rsp_exception, and rsp_tag keep their last values.
  - flush in IDLE with req_valid: the request is not accepted.
- Reset mid-operation: immediate return to IDLE with all reset values.
- unit_resultRDY or unit_exception outside WAIT is ignored.

Optional Feature:
MULTDIV_ZERO_BYPASS_EN
- Defined:
  - In IDLE, a multiply with req_a=0 or req_b=0 goes directly to DONE with rsp_result=0 and rsp_exception=0.
  - A divide with req_b=0 goes directly to DONE with rsp_result=0 and rsp_exception=1.
  - The unit is not started; rsp_valid rises 1 cycle after acceptance.
- Undefined: these operands are issued to the unit like any other request.
- The range check takes precedence over the bypass.

Test Plan:
- Reset held 2 cycles, then released -> req_ready=1, rsp_valid=0, both ctrl lines 0.
- Mult with a=7, b=6, tag=3; model asserts unit_resultRDY with result 42 on the 5th WAIT cycle; rsp_ready=1 -> unit_ctrl_MULT high from ISSUE until ready; rsp_valid with 42, exception 0, tag 3 for exactly 1 cycle; req_ready low throughout.
- Mult with b=0x00010000 -> no ctrl pulse; rsp_valid 1 cycle after acceptance with exception=1, result=0.
- Div issued; model never asserts ready; TIMEOUT_CYCLES=40 -> unit_ctrl_DIV high for 41 cycles (ISSUE + 40 WAIT); rsp_exception=1, result 0.
- Div issued; flush asserted in the 3rd WAIT cycle -> ctrl drops next edge; IDLE; no rsp_valid. A later unit_resultRDY pulse is ignored.
- DONE with rsp_ready=0 for 4 cycles while req_valid=1 -> rsp_* stable, req_ready=0. After rsp_ready=1, the next request is accepted one cycle later.
